// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller: FSM state encoding.
package dds_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } dds_state_e;

endpackage

// File: rtl/dds_sat_add.sv
// Clamped adder: min(a + b, limit). The sum is one bit wider so an overflowing
// add clamps to the limit instead of wrapping to a small value.
module dds_sat_add #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b};
    assign sum      = (full_sum > {1'b0, limit}) ? limit : full_sum[WIDTH-1:0];

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller: drives the increment/load ports of an external
// DDS phase accumulator through a start..stop ramp with a per-value dwell.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int PHASE_INC_WIDTH = 16,
    parameter int PHASE_ACC_WIDTH = 16,
    parameter int DWELL_WIDTH     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic                       cont_i,
    input  logic [PHASE_INC_WIDTH-1:0] inc_start_i,
    input  logic [PHASE_INC_WIDTH-1:0] inc_stop_i,
    input  logic [PHASE_INC_WIDTH-1:0] inc_step_i,
    input  logic [DWELL_WIDTH-1:0]     dwell_i,
    input  logic [PHASE_ACC_WIDTH-1:0] phase_init_i,
    output logic [PHASE_INC_WIDTH-1:0] phase_inc_o,
    output logic                       phase_inc_ena_o,
    output logic [PHASE_ACC_WIDTH-1:0] phase_load_o,
    output logic                       phase_load_ena_o,
    output logic                       busy_o,
    output logic                       step_o,
    output logic                       done_o
);

    dds_state_e                 state_q, state_d;
    logic [PHASE_INC_WIDTH-1:0] start_q, start_d;
    logic [PHASE_INC_WIDTH-1:0] stop_q, stop_d;
    logic [PHASE_INC_WIDTH-1:0] step_q, step_d;
    logic [DWELL_WIDTH-1:0]     dwell_q, dwell_d;
    logic                       cont_q, cont_d;
    logic [DWELL_WIDTH-1:0]     cnt_q, cnt_d;
    logic [PHASE_INC_WIDTH-1:0] inc_q, inc_d;
    logic                       inc_ena_q, inc_ena_d;
    logic [PHASE_ACC_WIDTH-1:0] load_q, load_d;
    logic                       load_ena_q, load_ena_d;
    logic                       busy_q, busy_d;
    logic                       step_pulse_q, step_pulse_d;
    logic                       done_q, done_d;

    logic [PHASE_INC_WIDTH-1:0] next_inc;
    logic [DWELL_WIDTH:0]       cnt_plus1;
    logic                       dwell_expired;

    dds_sat_add #(
        .WIDTH (PHASE_INC_WIDTH)
    ) u_sat_add (
        .a     (inc_q),
        .b     (step_q),
        .limit (stop_q),
        .sum   (next_inc)
    );

    // A dwell of 0 expires on the first cycle, exactly like a dwell of 1.
    assign cnt_plus1     = {1'b0, cnt_q} + {{DWELL_WIDTH{1'b0}}, 1'b1};
    assign dwell_expired = cnt_plus1 >= {1'b0, dwell_q};

    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        stop_d       = stop_q;
        step_d       = step_q;
        dwell_d      = dwell_q;
        cont_d       = cont_q;
        cnt_d        = cnt_q;
        inc_d        = inc_q;
        inc_ena_d    = inc_ena_q;
        load_d       = load_q;
        load_ena_d   = 1'b0;
        busy_d       = busy_q;
        step_pulse_d = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    start_d    = inc_start_i;
                    stop_d     = inc_stop_i;
                    step_d     = inc_step_i;
                    dwell_d    = dwell_i;
                    cont_d     = cont_i;
                    cnt_d      = '0;
                    inc_d      = inc_start_i;
                    load_d     = phase_init_i;
                    load_ena_d = 1'b1;
                    inc_ena_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                inc_ena_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (dwell_expired) begin
                    cnt_d = '0;
                    if (inc_q < stop_q) begin
                        inc_d        = next_inc;
                        step_pulse_d = 1'b1;
                    end else if (cont_q) begin
                        inc_d        = start_q;
                        step_pulse_d = 1'b1;
                    end else begin
                        inc_ena_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_plus1[DWELL_WIDTH-1:0];
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything: the increment value is frozen, not advanced.
        if (abort_i) begin
            state_d      = ST_IDLE;
            inc_d        = inc_q;
            cnt_d        = '0;
            inc_ena_d    = 1'b0;
            load_ena_d   = 1'b0;
            busy_d       = 1'b0;
            step_pulse_d = 1'b0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            start_q      <= '0;
            stop_q       <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            cont_q       <= 1'b0;
            cnt_q        <= '0;
            inc_q        <= '0;
            inc_ena_q    <= 1'b0;
            load_q       <= '0;
            load_ena_q   <= 1'b0;
            busy_q       <= 1'b0;
            step_pulse_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            step_q       <= step_d;
            dwell_q      <= dwell_d;
            cont_q       <= cont_d;
            cnt_q        <= cnt_d;
            inc_q        <= inc_d;
            inc_ena_q    <= inc_ena_d;
            load_q       <= load_d;
            load_ena_q   <= load_ena_d;
            busy_q       <= busy_d;
            step_pulse_q <= step_pulse_d;
            done_q       <= done_d;
        end
    end

    assign phase_inc_o      = inc_q;
    assign phase_inc_ena_o  = inc_ena_q;
    assign phase_load_o     = load_q;
    assign phase_load_ena_o = load_ena_q;
    assign busy_o           = busy_q;
    assign step_o           = step_pulse_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a behavioural sweep model queues the
// expected per-cycle output word, and each cycle the DUT outputs are popped and compared.
module tb_dds_sweep_ctrl;

    localparam int IW = 16;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          abort_i;
    logic          cont_i;
    logic [IW-1:0] inc_start_i;
    logic [IW-1:0] inc_stop_i;
    logic [IW-1:0] inc_step_i;
    logic [DW-1:0] dwell_i;
    logic [AW-1:0] phase_init_i;
    logic [IW-1:0] phase_inc_o;
    logic          phase_inc_ena_o;
    logic [AW-1:0] phase_load_o;
    logic          phase_load_ena_o;
    logic          busy_o;
    logic          step_o;
    logic          done_o;

    logic [63:0]   exp_q[$];
    logic [63:0]   obs_w;
    logic [IW-1:0] last_inc;
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(
        .PHASE_INC_WIDTH (IW),
        .PHASE_ACC_WIDTH (AW),
        .DWELL_WIDTH     (DW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .cont_i           (cont_i),
        .inc_start_i      (inc_start_i),
        .inc_stop_i       (inc_stop_i),
        .inc_step_i       (inc_step_i),
        .dwell_i          (dwell_i),
        .phase_init_i     (phase_init_i),
        .phase_inc_o      (phase_inc_o),
        .phase_inc_ena_o  (phase_inc_ena_o),
        .phase_load_o     (phase_load_o),
        .phase_load_ena_o (phase_load_ena_o),
        .busy_o           (busy_o),
        .step_o           (step_o),
        .done_o           (done_o)
    );

    // Word layout: {busy, inc_ena, load_ena, step, done, phase_inc, phase_load}
    function automatic logic [63:0] pack(input logic busy, input logic ena, input logic lena,
                                         input logic stp, input logic dn,
                                         input logic [15:0] inc, input logic [15:0] ld);
        return {27'd0, busy, ena, lena, stp, dn, inc, ld};
    endfunction

    assign obs_w = pack(busy_o, phase_inc_ena_o, phase_load_ena_o, step_o, done_o,
                        phase_inc_o, phase_load_o);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, expv);
        end
    endtask

    // Reference sweep: LOAD word, then RUN words (each value held max(dwell,1) cycles,
    // step flagged on the first cycle of every new value), then DONE and idle words.
    task automatic gen_sweep(input int st, input int sp, input int stp, input int dwell,
                             input bit cont, input logic [15:0] init,
                             input int max_run, input int n_idle);
        int  d;
        int  v;
        int  run;
        bit  ended;
        d     = (dwell == 0) ? 1 : dwell;
        v     = st;
        run   = 0;
        ended = 1'b0;
        exp_q.push_back(pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'(st), init));
        while (run < max_run && !ended) begin
            for (int c = 0; c < d && run < max_run; c++) begin
                exp_q.push_back(pack(1'b1, 1'b1, 1'b0, (c == 0 && run > 0), 1'b0, 16'(v), init));
                run++;
            end
            if (run >= max_run) break;
            if (v >= sp) begin
                if (cont) v = st;
                else ended = 1'b1;
            end else begin
                v = (v + stp > sp) ? sp : v + stp;
            end
        end
        last_inc = 16'(v);
        if (ended) begin
            exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'(v), init));
            for (int i = 0; i < n_idle; i++)
                exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'(v), init));
        end
    endtask

    task automatic push_idle(input int n, input logic [15:0] init);
        for (int i = 0; i < n; i++)
            exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_inc, init));
    endtask

    task automatic start_sweep(input logic [15:0] st, input logic [15:0] sp, input logic [15:0] stp,
                               input logic [15:0] dwell, input logic cont, input logic [15:0] init);
        inc_start_i  = st;
        inc_stop_i   = sp;
        inc_step_i   = stp;
        dwell_i      = dwell;
        cont_i       = cont;
        phase_init_i = init;
        start_i      = 1'b1;
        $display("sweep: start=%h stop=%h step=%h dwell=%0d cont=%0b init=%h", st, sp, stp, dwell, cont, init);
    endtask

    // Compares n queued words, one per cycle; optionally fires abort or a
    // start-plus-config disturbance right after comparison index abort_at / mutate_at.
    task automatic drain(input int n, input int abort_at, input int mutate_at, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            abort_i = 1'b0;
            if (exp_q.size() == 0) chk({tag, "_underrun"}, obs_w, 64'hFFFF_FFFF_FFFF_FFFF);
            else                   chk(tag, obs_w, exp_q.pop_front());
            if (k == abort_at) abort_i = 1'b1;
            if (k == mutate_at) begin
                start_i      = 1'b1;
                inc_start_i  = 16'h0003;
                inc_stop_i   = 16'h0100;
                inc_step_i   = 16'h0001;
                dwell_i      = 16'd1;
                cont_i       = 1'b1;
                phase_init_i = 16'hBEEF;
            end
        end
    endtask

    initial begin
        rst_i        = 1'b1;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        cont_i       = 1'b0;
        inc_start_i  = '0;
        inc_stop_i   = '0;
        inc_step_i   = '0;
        dwell_i      = '0;
        phase_init_i = '0;
        last_inc     = '0;

        #1 chk("reset", obs_w, 64'd0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", obs_w, 64'd0);

        // Single sweep 10..40 step 10 dwell 3
        start_sweep(16'd10, 16'd40, 16'd10, 16'd3, 1'b0, 16'h1234);
        gen_sweep(10, 40, 10, 3, 1'b0, 16'h1234, 1000, 2);
        drain(exp_q.size(), -1, -1, "single");

        // Clamp instead of wrap near full scale
        start_sweep(16'hFFF0, 16'hFFFF, 16'h0020, 16'd2, 1'b0, 16'h0000);
        gen_sweep(32'hFFF0, 32'hFFFF, 32'h0020, 2, 1'b0, 16'h0000, 1000, 2);
        drain(exp_q.size(), -1, -1, "wrap_clamp");

        // Continuous 5..7, ended only by abort
        start_sweep(16'd5, 16'd7, 16'd1, 16'd1, 1'b1, 16'h00AA);
        gen_sweep(5, 7, 1, 1, 1'b1, 16'h00AA, 9, 0);
        push_idle(2, 16'h00AA);
        drain(exp_q.size(), 9, -1, "continuous");

        // Abort during the fourth RUN cycle
        start_sweep(16'd10, 16'd40, 16'd10, 16'd3, 1'b0, 16'h0055);
        gen_sweep(10, 40, 10, 3, 1'b0, 16'h0055, 4, 0);
        push_idle(2, 16'h0055);
        drain(exp_q.size(), 4, -1, "abort_run");

        // start_i and config changes during RUN must not disturb the sweep
        start_sweep(16'd10, 16'd40, 16'd10, 16'd3, 1'b0, 16'h0077);
        gen_sweep(10, 40, 10, 3, 1'b0, 16'h0077, 1000, 2);
        drain(exp_q.size(), -1, 3, "ignore_busy");

        // start >= stop: one dwell at start, then done
        start_sweep(16'd50, 16'd20, 16'd5, 16'd2, 1'b0, 16'h0001);
        gen_sweep(50, 20, 5, 2, 1'b0, 16'h0001, 1000, 2);
        drain(exp_q.size(), -1, -1, "start_ge_stop");

        // step = 0 holds start until aborted
        start_sweep(16'd3, 16'd9, 16'd0, 16'd4, 1'b0, 16'h0002);
        gen_sweep(3, 9, 0, 4, 1'b0, 16'h0002, 20, 0);
        push_idle(2, 16'h0002);
        drain(exp_q.size(), 20, -1, "step_zero");

        // Reset mid-sweep, then dwell=0 with start == stop
        start_sweep(16'd10, 16'd40, 16'd10, 16'd3, 1'b0, 16'h0009);
        gen_sweep(10, 40, 10, 3, 1'b0, 16'h0009, 1000, 0);
        drain(5, -1, -1, "pre_reset");
        exp_q.delete();
        #2 rst_i = 1'b1;
        #1 chk("async_reset", obs_w, 64'd0);
        @(negedge clk);
        rst_i    = 1'b0;
        last_inc = '0;
        start_sweep(16'd9, 16'd9, 16'd1, 16'd0, 1'b0, 16'h0909);
        gen_sweep(9, 9, 1, 0, 1'b0, 16'h0909, 1000, 2);
        drain(exp_q.size(), -1, -1, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
